banner_scroll_buffer: RTL and testbench
=======================================

Name: banner_scroll_buffer

Overview:
Loadable message buffer and scroller that produces the 4-digit hex window consumed by seven_seg_mux (hex3..hex0 = hex[15:12]..hex[3:0]). Replaces a fixed 32-bit constant message with a run-time message of 1..DEPTH hex digits. Digits are written one at a time through a valid/ready port, then committed. The window then rotates through the message at a divided tick rate, wrapping at the actual message length.

Parameters:
DEPTH, 16, maximum message length in digits; power of 2, >= 4
TICK_DIV, 50_000_000, clk cycles per scroll step; >= 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
wr_valid  input  1  digit offered on wr_data
wr_data  input  4  hex digit to append
wr_ready  output  1  buffer accepts a digit this cycle
commit  input  1  end of message; start scrolling
clear  input  1  synchronous discard of message, return to EMPTY
en  input  1  1 = scroll on tick, 0 = hold window
dir  input  1  0 = left (pos+1), 1 = right (pos-1)
hex  output  16  registered window {d[pos], d[pos+1], d[pos+2], d[pos+3]}, indices mod len
len  output  $clog2(DEPTH)+1  committed message length; 0 when none
scrolling  output  1  high in SCROLL state

Behaviour:
- Reset (reset=0): state=EMPTY, count=0, len=0, pos=0, tick counter=0, hex=16'h0000, wr_ready=1, scrolling=0. Buffer contents are don't-care.
- A write is accepted in a cycle with wr_valid & wr_ready.
- wr_ready = (state != SCROLL) & (count < DEPTH).
- State EMPTY:
  - Accepted write: store d[0]=wr_data, count=1, hex <= {hex[11:0], wr_data}, go to LOAD.
  - commit is ignored.
- State LOAD:
  - Accepted write: d[count]=wr_data, count+1, hex <= {hex[11:0], wr_data} (calculator-style entry echo).
  - commit: go to SCROLL with len = count after this cycle's write. A simultaneous accepted write is included.
  - At count==DEPTH, writes are refused and commit gives len=DEPTH.
- Entering SCROLL, on the commit edge:
  - pos=0, tick counter=0, scrolling=1.
  - On the following edge, hex = window at pos 0.
- State SCROLL:
  - Tick counter runs 0..TICK_DIV-1 continuously, independent of en.
  - Step cycle = counter==TICK_DIV-1 with en=1.
  - On a step: pos <= (pos+1) mod len if dir=0, or (pos-1+len) mod len if dir=1.
  - hex is recomputed every cycle from the current pos and registered, so it updates one edge after pos.
  - Index arithmetic uses compare/subtract modulo len (len need not be a power of 2).
  - If len<4, digits repeat within the window.
  - Writes are ignored (wr_ready=0). commit is ignored.
  - en=0 holds pos, and therefore hex.
- clear, any state: next edge gives state=EMPTY, count=0, len=0, pos=0, hex=0000, scrolling=0.
  - clear has priority over a simultaneous write or commit, which are dropped.
- dir may change at any time; it is sampled only on step cycles.
- Asserting reset mid-load or mid-scroll discards everything, as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> hex=0000, len=0, wr_ready=1, scrolling=0. Pulse commit -> still EMPTY.
- Entry echo and scroll left (TICK_DIV=4): write 0,1,2,3,4 -> hex=1234. Write 5,6,7, then commit -> len=8, hex=0123. Set en=1, dir=0 -> hex 1234 on the first step, then 2345, ..., 7012. The 8th step returns 0123.
- Scroll right: 8-digit message 0..7, dir=1 -> steps give hex 7012, then 6701.
- Short message: write A,B, then commit -> len=2, hex=ABAB. One step -> BABA. Second step -> ABAB.
- Full buffer: write 15 digits, then assert wr_valid and commit together with F -> len=16, F stored as d[15]. Alternatively, write 16 digits -> wr_ready=0, and a 17th write is not stored.
- Hold and clear: during scroll with en=0 for 3 ticks -> hex unchanged. Assert clear together with wr_valid -> next edge gives hex=0000, len=0, wr_ready=1, and the digit is not stored.

Source files
------------

// File: rtl/banner_scroll_buffer.sv
`default_nettype none
// ============================================================================
// Module      : banner_scroll_buffer
// Description : Run-time loadable hex message buffer that scrolls a 4-digit
//               window through the message at a divided tick rate.
// Revision    : 1.0 - initial release
// ============================================================================
module banner_scroll_buffer #(
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_valid,
   input  logic [3:0]             wr_data,
   output logic                   wr_ready,
   input  logic                   commit,
   input  logic                   clear,
   input  logic                   en,
   input  logic                   dir,
   output logic [15:0]            hex,
   output logic [$clog2(DEPTH):0] len,
   output logic                   scrolling
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TICK_DIV);

   localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
   localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SCROLL = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [3:0]     r_mem [DEPTH];
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  r_len;
   logic [AW-1:0]  r_pos;
   logic [TW-1:0]  r_tick;
   logic [15:0]    r_hex;

   logic           w_ready;
   logic           w_wr;
   logic           w_step;
   logic [CW-1:0]  w_pos_inc;
   logic [CW-1:0]  w_pos_up;
   logic [CW-1:0]  w_pos_dn;
   logic [CW-1:0]  w_pos_nxt;
   logic [15:0]    w_window;
   logic [3:0]     w_idx_msb;
   logic           w_unused;

   assign w_ready = (r_state != ST_SCROLL) && (r_count < c_depth);
   assign w_wr    = wr_valid && w_ready && !clear;
   assign w_step  = (r_state == ST_SCROLL) && (r_tick == c_tick_last) && en;

   // Position wraps by compare/subtract so any length 1..DEPTH works.
   assign w_pos_inc = CW'(r_pos) + CW'(1);
   assign w_pos_up  = (w_pos_inc == r_len) ? '0 : w_pos_inc;
   assign w_pos_dn  = (r_pos == '0) ? (r_len - CW'(1)) : (CW'(r_pos) - CW'(1));
   assign w_pos_nxt = dir ? w_pos_dn : w_pos_up;

   // Each window digit index is pos+k reduced modulo len; three subtractions
   // suffice because pos < len and k <= 3 even when len is 1.
   for (genvar gk = 0; gk < 4; gk++) begin : g_win
      logic [CW-1:0] w_idx;
      always_comb begin
         w_idx = CW'(r_pos) + CW'(gk);
         for (int i = 0; i < 3; i++) begin
            if (w_idx >= r_len) begin
               w_idx = w_idx - r_len;
            end
         end
      end
      assign w_window[15-4*gk -: 4] = r_mem[w_idx[AW-1:0]];
      assign w_idx_msb[gk]          = w_idx[AW];
   end

   assign w_unused = ^{w_idx_msb, w_pos_nxt[AW]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY:  if (w_wr)   w_state_nxt = ST_LOAD;
            ST_LOAD:   if (commit) w_state_nxt = ST_SCROLL;
            ST_SCROLL: w_state_nxt = ST_SCROLL;
            default:   w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_len   <= '0;
         r_pos   <= '0;
         r_tick  <= '0;
         r_hex   <= '0;
      end else if (clear) begin
         r_count <= '0;
         r_len   <= '0;
         r_pos   <= '0;
         r_tick  <= '0;
         r_hex   <= '0;
      end else begin
         case (r_state)
            ST_EMPTY, ST_LOAD: begin
               if (w_wr) begin
                  r_count <= r_count + CW'(1);
                  r_hex   <= {r_hex[11:0], wr_data};
               end
               // A write landing on the commit edge is part of the message.
               if ((r_state == ST_LOAD) && commit) begin
                  r_len  <= r_count + CW'(w_wr);
                  r_pos  <= '0;
                  r_tick <= '0;
               end
            end
            ST_SCROLL: begin
               r_tick <= (r_tick == c_tick_last) ? '0 : (r_tick + TW'(1));
               if (w_step) begin
                  r_pos <= w_pos_nxt[AW-1:0];
               end
               r_hex <= w_window;
            end
            default: begin
               r_count <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_count[AW-1:0]] <= wr_data;
      end
   end

   assign wr_ready  = w_ready;
   assign hex       = r_hex;
   assign len       = r_len;
   assign scrolling = (r_state == ST_SCROLL);

endmodule
`default_nettype wire

// File: tb/tb_banner_scroll_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_banner_scroll_buffer
// Description : Directed self-checking bench for banner_scroll_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banner_scroll_buffer;

   localparam int DEPTH    = 16;
   localparam int TICK_DIV = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        wr_valid = 1'b0;
   logic [3:0]  wr_data  = 4'h0;
   logic        commit   = 1'b0;
   logic        clear    = 1'b0;
   logic        en       = 1'b0;
   logic        dir      = 1'b0;
   logic        wr_ready;
   logic [15:0] hex;
   logic [4:0]  len;
   logic        scrolling;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  msg [DEPTH];
   int          mlen;

   banner_scroll_buffer #(
      .DEPTH    (DEPTH),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .commit    (commit),
      .clear     (clear),
      .en        (en),
      .dir       (dir),
      .hex       (hex),
      .len       (len),
      .scrolling (scrolling)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   function automatic logic [15:0] win(input int p);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w = {w[11:0], msg[(p + k) % mlen]};
      end
      return w;
   endfunction

   initial begin
      int p;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hex_during", hex, 16'h0000);
      reset = 1'b1;
      tick();
      chk("rst_hex", hex, 16'h0000);
      chk("rst_len", len, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_scroll", scrolling, 0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("empty_commit_scroll", scrolling, 0);
      chk("empty_commit_len", len, 0);
      chk("empty_commit_ready", wr_ready, 1);

      // Entry echo, then 8-digit message scrolled left
      for (int i = 0; i < 5; i++) put(4'(i));
      chk("echo_1234", hex, 16'h1234);
      chk("load_not_scroll", scrolling, 0);
      for (int i = 5; i < 8; i++) put(4'(i));
      chk("echo_4567", hex, 16'h4567);
      for (int i = 0; i < 8; i++) msg[i] = 4'(i);
      mlen = 8;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("commit_len8", len, 8);
      chk("commit_scroll", scrolling, 1);
      chk("scroll_ready0", wr_ready, 0);
      tick();
      chk("first_window", hex, 16'h0123);
      en  = 1'b1;
      dir = 1'b0;
      p   = 0;
      for (int s = 0; s < 8; s++) begin
         repeat (3) tick();
         chk("left_hold", hex, win(p));
         tick();
         p = (p + 1) % mlen;
         chk("left_step", hex, win(p));
      end
      chk("left_wrap_0123", hex, 16'h0123);

      // Scroll right
      dir = 1'b1;
      repeat (4) tick();
      chk("right_7012", hex, 16'h7012);
      repeat (4) tick();
      chk("right_6701", hex, 16'h6701);

      // Hold with en=0 across three tick periods
      en = 1'b0;
      repeat (12) tick();
      chk("hold_6701", hex, 16'h6701);

      // Clear with a simultaneous write
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 4'h9;
      tick();
      clear    = 1'b0;
      wr_valid = 1'b0;
      chk("clear_hex", hex, 16'h0000);
      chk("clear_len", len, 0);
      chk("clear_ready", wr_ready, 1);
      chk("clear_scroll", scrolling, 0);

      // Short message repeats within the window
      put(4'hA);
      put(4'hB);
      chk("short_echo", hex, 16'h00AB);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("short_len", len, 2);
      tick();
      chk("short_abab", hex, 16'hABAB);
      en  = 1'b1;
      dir = 1'b0;
      repeat (4) tick();
      chk("short_baba", hex, 16'hBABA);
      repeat (4) tick();
      chk("short_abab2", hex, 16'hABAB);
      en = 1'b0;

      // Full buffer: 16th digit arrives with commit
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 15; i++) put(4'(i));
      chk("full15_ready", wr_ready, 1);
      wr_valid = 1'b1;
      wr_data  = 4'hF;
      commit   = 1'b1;
      tick();
      wr_valid = 1'b0;
      commit   = 1'b0;
      chk("full_len16", len, 16);
      chk("full_scroll", scrolling, 1);
      tick();
      chk("full_window0", hex, 16'h0123);
      en  = 1'b1;
      dir = 1'b1;
      repeat (4) tick();
      chk("full_right_F012", hex, 16'hF012);
      en = 1'b0;

      // Full buffer: 17th write refused
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 16; i++) put(4'(15 - i));
      chk("full16_ready0", wr_ready, 0);
      chk("full16_echo", hex, 16'h3210);
      put(4'h5);
      chk("refused_echo", hex, 16'h3210);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("refused_len16", len, 16);
      tick();
      chk("refused_window", hex, 16'hFEDC);

      // Asynchronous reset mid-scroll
      en = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("areset_hex", hex, 16'h0000);
      chk("areset_len", len, 0);
      chk("areset_scroll", scrolling, 0);
      chk("areset_ready", wr_ready, 1);
      en = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
